inner_product_loader: RTL

//  Upstream stage of inner_product: takes one (a,b) element pair per cycle over a valid/ready stream.

---
 rtl/inner_product_pkg.sv | 23 ++
 rtl/inner_product_loader_if.sv | 41 ++++
 rtl/inner_product_bank.sv | 86 ++++++++
 rtl/inner_product_loader.sv | 101 ++++++++++
 4 files changed

// File: rtl/inner_product_pkg.sv
// ---------------------------------------------------------------------------
// inner_product_pkg
// Shared types and constants for the inner_product loader slice.
//   bank_state_t : life cycle of one ping-pong bank (EMPTY -> FILLING -> FULL)
//   OUT_COUNT_W  : width of the transferred-vector counter
//   idx_width()  : element-index width, never less than one bit
// ---------------------------------------------------------------------------
package inner_product_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    localparam int OUT_COUNT_W = 8;

    // A single-element vector still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/inner_product_loader_if.sv
// ---------------------------------------------------------------------------
// inner_product_loader_if
// Input element stream and output vector stream of the loader.
//   in_valid/in_ready/in_a/in_b/in_last : one (a,b) element pair per transfer
//   out_valid/out_ready/out_a/out_b     : one packed vector pair per transfer
//   out_count                           : vectors transferred out (wraps)
//   err_len                             : sticky wrong-length flag
// Modports:
//   master : producer/consumer environment around the loader
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface inner_product_loader_if
    import inner_product_pkg::*;
#(
    parameter int data_width = 3,
    parameter int num_elems  = 3
);

    logic                            in_valid;
    logic                            in_ready;
    logic [data_width-1:0]           in_a;
    logic [data_width-1:0]           in_b;
    logic                            in_last;
    logic                            out_valid;
    logic                            out_ready;
    logic [num_elems*data_width-1:0] out_a;
    logic [num_elems*data_width-1:0] out_b;
    logic [OUT_COUNT_W-1:0]          out_count;
    logic                            err_len;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_count, err_len
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_a, out_b, out_count, err_len
    );

endinterface

// File: rtl/inner_product_bank.sv
// ---------------------------------------------------------------------------
// inner_product_bank
// One ping-pong bank: holds a vector pair element by element, tracks its own
// EMPTY/FILLING/FULL state and presents the packed contents continuously.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   wr_en         : write element wr_idx with wr_a/wr_b (ignored while FULL)
//   wr_idx        : element index of the write
//   wr_a, wr_b    : element values
//   close         : this write completes the vector (bank becomes FULL)
//   clear         : the consumer took the vector (bank returns EMPTY, zeroed)
//   state         : current bank state
//   rd_a, rd_b    : packed vectors, element i at [i*data_width +: data_width]
// ---------------------------------------------------------------------------
module inner_product_bank
    import inner_product_pkg::*;
#(
    parameter  int data_width = 3,
    parameter  int num_elems  = 3,
    localparam int idx_w      = idx_width(num_elems)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [idx_w-1:0]                wr_idx,
    input  logic [data_width-1:0]           wr_a,
    input  logic [data_width-1:0]           wr_b,
    input  logic                            close,
    input  logic                            clear,
    output bank_state_t                     state,
    output logic [num_elems*data_width-1:0] rd_a,
    output logic [num_elems*data_width-1:0] rd_b
);

    bank_state_t state_q, state_d;
    logic        store_en;
    logic        zero_en;

    // Packed element arrays have exactly the output bus layout.
    logic [num_elems-1:0][data_width-1:0] a_q;
    logic [num_elems-1:0][data_width-1:0] b_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BANK_EMPTY;
        else     state_q <= state_d;
    end

    // NOTE: default assignment first so no path through the case leaves
    // state_d unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BANK_EMPTY:   if (wr_en) state_d = close ? BANK_FULL : BANK_FILLING;
            BANK_FILLING: if (wr_en && close) state_d = BANK_FULL;
            BANK_FULL:    if (clear) state_d = BANK_EMPTY;
            default:      state_d = BANK_EMPTY;
        endcase
    end

    always_comb begin
        state    = state_q;
        store_en = wr_en && (state_q != BANK_FULL);
        zero_en  = clear && (state_q == BANK_FULL);
    end

    // NOTE: the element storage is reset on purpose: an EMPTY bank must read
    // as zero so a short vector presents zeros in its unwritten elements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (zero_en) begin
            a_q <= '0;
            b_q <= '0;
        end else if (store_en) begin
            a_q[wr_idx] <= wr_a;
            b_q[wr_idx] <= wr_b;
        end
    end

    assign rd_a = a_q;
    assign rd_b = b_q;

endmodule

// File: rtl/inner_product_loader.sv
// ---------------------------------------------------------------------------
// inner_product_loader
// Upstream stage of inner_product. Packs a stream of (a,b) element pairs into
// vector pairs of num_elems elements using two ping-pong banks, and hands the
// complete pairs on in arrival order over a valid/ready handshake.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, discards any partial vector
//   bus  : inner_product_loader_if.slave (element input, vector output,
//          out_count, err_len)
// ---------------------------------------------------------------------------
module inner_product_loader
    import inner_product_pkg::*;
#(
    parameter int data_width = 3,
    parameter int num_elems  = 3
) (
    input logic                  clk,
    input logic                  rst,
    inner_product_loader_if.slave bus
);

    localparam int              idx_w    = idx_width(num_elems);
    localparam int              vec_w    = num_elems * data_width;
    localparam logic [idx_w-1:0] last_idx = idx_w'(num_elems - 1);

    logic [idx_w-1:0]       idx_q;
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [OUT_COUNT_W-1:0] count_q;
    logic                   err_q;

    logic in_fire;
    logic out_fire;
    logic in_close;
    logic len_bad;

    bank_state_t      bank_state [2];
    logic [vec_w-1:0] bank_a     [2];
    logic [vec_w-1:0] bank_b     [2];

    // Ready depends only on the bank being filled, so the consumer never
    // stalls the producer unless both banks are FULL.
    assign bus.in_ready  = !rst && (bank_state[wr_ptr_q] != BANK_FULL);
    assign bus.out_valid = (bank_state[rd_ptr_q] == BANK_FULL);
    assign bus.out_a     = bank_a[rd_ptr_q];
    assign bus.out_b     = bank_b[rd_ptr_q];
    assign bus.out_count = count_q;
    assign bus.err_len   = err_q;

    always_comb begin
        in_fire  = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;
        // A vector closes at the last slot or on in_last, whichever comes
        // first; the length is wrong whenever the two disagree.
        in_close = in_fire && ((idx_q == last_idx) || bus.in_last);
        len_bad  = in_fire && ((idx_q == last_idx) != bus.in_last);
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        inner_product_bank #(
            .data_width (data_width),
            .num_elems  (num_elems)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (in_fire && (wr_ptr_q == 1'(g))),
            .wr_idx (idx_q),
            .wr_a   (bus.in_a),
            .wr_b   (bus.in_b),
            .close  (in_close),
            .clear  (out_fire && (rd_ptr_q == 1'(g))),
            .state  (bank_state[g]),
            .rd_a   (bank_a[g]),
            .rd_b   (bank_b[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (in_close) begin
                idx_q    <= '0;
                wr_ptr_q <= ~wr_ptr_q;
            end else if (in_fire) begin
                idx_q <= idx_q + 1'b1;
            end
            if (out_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
                count_q  <= count_q + 1'b1;
            end
            if (len_bad) err_q <= 1'b1;
        end
    end

endmodule
